nfa_report_buffer: RTL and testbench
====================================

# nfa_report_buffer

Collects report events from the reporting state-transition elements of an NFA automata cluster and buffers them for the host-side result path. Each cycle the cluster consumes a symbol, the OR of the reporting STEs' active states decides whether a report entry is pushed. The entry holds the report vector tagged with the symbol offset within the current data stream. It sits directly downstream of the STE array and presents a valid/ready stream to the engine's result writer.

## Interface
- NUM_REPORTS, 8, number of reporting STE outputs collected (≥1)
- DEPTH, 16, FIFO entries; power of two, ≥2
- OFFSET_W, 32, width of symbol-offset tag
- DROP_W, 16, width of dropped-report counter
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  a symbol is consumed this cycle (same strobe as the STE array)
- start_of_data  in  1  current symbol is first of a new stream
- report_states  in  NUM_REPORTS  active_state outputs of the reporting STEs, same cycle as run
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_offset  out  OFFSET_W  symbol offset of head entry
- out_vector  out  NUM_REPORTS  report vector of head entry
- overflow  out  1  sticky; at least one report dropped since reset
- dropped_count  out  DROP_W  reports dropped since reset, saturating

## Operation
- Offset counter cnt (OFFSET_W). Per cycle: tag = (start_of_data ? 0 : cnt). If run=1, cnt ← tag+1, wrapping modulo 2^OFFSET_W. If run=0, cnt holds; start_of_data is ignored.
- Push condition: run=1 and |report_states. Entry = {tag, report_states}.
- Pop condition: out_valid & out_ready.
- FIFO not full: push accepted.
- FIFO full, pop in the same cycle: push accepted; count unchanged.
- FIFO full, no pop: entry dropped. overflow ← 1. dropped_count increments, saturating at all-ones.
- Pop with empty FIFO is impossible, because out_valid=0.
- Output is first-word-fall-through:
  - out_valid = FIFO non-empty.
  - out_offset and out_vector show the head entry.
  - Both are forced to 0 when empty.
- out_valid never deasserts without a pop.
- Head data is stable while out_valid=1 and out_ready=0.
- run=0 blocks capture only. The output handshake continues to drain.
- Reset (any time, including mid-stream):
  - Pointers, count and cnt are cleared to 0.
  - overflow=0, dropped_count=0, out_valid=0, out_offset=0, out_vector=0.
  - Buffered entries are discarded.
- Counters and flags persist across start_of_data. Only reset clears them.

## Timing
- Push in cycle t → entry visible (out_valid=1) from cycle t+1. Latency is 1 cycle.
- Pop in cycle t → next entry (or out_valid=0) from cycle t+1.
- overflow and dropped_count update in the cycle after the dropped push.
- Throughput: one push and one pop per cycle, sustained.
- No combinational path from out_ready to out_valid or data.
- Combinational paths from report_states, run and start_of_data reach only registers, never outputs.

## Structure
- Shared package nfa_report_pkg holds:
  - entry width ENTRY_W = OFFSET_W + NUM_REPORTS;
  - field-offset constants for packing and unpacking;
  - a clog2 helper for pointer and count widths.
- Sub-module nfa_report_fifo:
  - synchronous FWFT FIFO, DEPTH × ENTRY_W;
  - async reset;
  - outputs full and empty;
  - accepts push and pop in the same cycle when full.
- Top level holds the offset counter, push/drop logic, overflow/dropped counters and output masking.

## Test plan
- Reset release, run=1 for 5 cycles, start_of_data on cycle 0, report_states=8'h04 on cycle 3 only → one entry, out_offset=3, out_vector=8'h04, out_valid rises the cycle after.
- start_of_data re-asserted at cnt=100 with report_states=8'h01 the same cycle → entry offset 0; the next reporting symbol tags offset 1.
- out_ready=0, 20 consecutive reports (DEPTH=16) → 16 entries retained with offsets 0–15; dropped_count=4; overflow=1. Then drain with out_ready=1 → entries pop in order, out_valid falls after the 16th.
- FIFO full, out_ready=1 and a report in the same cycle → no drop; count stays 16; new entry appears last.
- run=0 with report_states=8'hFF for 3 cycles → no push; cnt unchanged.
- Async reset asserted mid-drain with 5 entries buffered → out_valid, out_offset, out_vector, overflow and dropped_count all 0 immediately, with no clock edge needed; the next report after release tags offset 0.

Source files
------------

// File: rtl/nfa_report_pkg.sv
// Shared constants and helpers for the NFA report buffer: entry layout
// (report vector in the low bits, symbol offset above it) and width helpers.
package nfa_report_pkg;

  localparam int NUM_REPORTS_DEF = 8;
  localparam int DEPTH_DEF       = 16;
  localparam int OFFSET_W_DEF    = 32;
  localparam int DROP_W_DEF      = 16;

  // Report vector occupies the least significant bits of an entry.
  localparam int VEC_LSB = 0;

  // Total entry width: offset tag plus report vector.
  function automatic int entry_w(input int off_w, input int nrep);
    return off_w + nrep;
  endfunction

  // The offset tag sits directly above the report vector.
  function automatic int off_lsb(input int nrep);
    return VEC_LSB + nrep;
  endfunction

  localparam int ENTRY_W = entry_w(OFFSET_W_DEF, NUM_REPORTS_DEF);

  // Ceiling log2, used for pointer and occupancy widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nfa_report_fifo.sv
// First-word-fall-through FIFO. The head entry is always visible on rdata;
// a push and a pop may share a cycle even when the FIFO is full.
module nfa_report_fifo
  import nfa_report_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents are only meaningful between the pointers.
  // NOTE: the memory array has no reset -- stale words are never observed
  // because occupancy is reset, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nfa_report_buffer.sv
// Report buffer behind the STE array: tags each reporting symbol with its
// offset in the current stream, queues it, and counts reports lost to a
// full queue. Outputs depend only on registered state.
module nfa_report_buffer
  import nfa_report_pkg::*;
#(
  parameter int NUM_REPORTS = NUM_REPORTS_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int OFFSET_W    = OFFSET_W_DEF,
  parameter int DROP_W      = DROP_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   start_of_data,
  input  logic [NUM_REPORTS-1:0] report_states,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OFFSET_W-1:0]    out_offset,
  output logic [NUM_REPORTS-1:0] out_vector,
  output logic                   overflow,
  output logic [DROP_W-1:0]      dropped_count
);

  localparam int EW      = entry_w(OFFSET_W, NUM_REPORTS);
  localparam int OFF_LSB = off_lsb(NUM_REPORTS);

  logic [OFFSET_W-1:0] cnt;
  logic [OFFSET_W-1:0] tag;
  logic                push;
  logic                pop;
  logic                drop;
  logic                full;
  logic                empty;
  logic [EW-1:0]       wentry;
  logic [EW-1:0]       head;

  // Tag selection, push/pop/drop decisions and entry packing.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tag    = start_of_data ? '0 : cnt;
    push   = run & (|report_states);
    pop    = out_ready & ~empty;
    drop   = push & full & ~pop;
    wentry = '0;
    wentry[OFF_LSB +: OFFSET_W]   = tag;
    wentry[VEC_LSB +: NUM_REPORTS] = report_states;
  end

  // Symbol offset counter; advances only on consumed symbols and wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (run) cnt <= tag + 1'b1;
  end

  // Sticky overflow flag and saturating count of dropped reports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropped_count != '1) dropped_count <= dropped_count + 1'b1;
    end
  end

  nfa_report_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Head presentation, masked to zero while nothing is buffered.
  always_comb begin
    out_valid  = ~empty;
    out_offset = empty ? '0 : head[OFF_LSB +: OFFSET_W];
    out_vector = empty ? '0 : head[VEC_LSB +: NUM_REPORTS];
  end

endmodule

// File: tb/tb_nfa_report_buffer.sv
// Self-checking bench for nfa_report_buffer: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_nfa_report_buffer;

  localparam int NR    = 8;
  localparam int DEPTH = 16;
  localparam int OW    = 32;
  localparam int DW    = 16;

  logic          clk;
  logic          reset;
  logic          run;
  logic          start_of_data;
  logic [NR-1:0] report_states;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_offset;
  logic [NR-1:0] out_vector;
  logic          overflow;
  logic [DW-1:0] dropped_count;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [OW+NR-1:0] q[$];
  logic [OW-1:0]    m_cnt;
  logic             m_ovf;
  logic [DW-1:0]    m_drop;

  nfa_report_buffer #(
    .NUM_REPORTS (NR),
    .DEPTH       (DEPTH),
    .OFFSET_W    (OW),
    .DROP_W      (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .start_of_data (start_of_data),
    .report_states (report_states),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_offset    (out_offset),
    .out_vector    (out_vector),
    .overflow      (overflow),
    .dropped_count (dropped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_valid();
    return q.size() != 0;
  endfunction

  function automatic logic [OW-1:0] exp_off();
    logic [OW+NR-1:0] e;
    if (q.size() == 0) return '0;
    e = q[0];
    return e[OW+NR-1:NR];
  endfunction

  function automatic logic [NR-1:0] exp_vec();
    logic [OW+NR-1:0] e;
    if (q.size() == 0) return '0;
    e = q[0];
    return e[NR-1:0];
  endfunction

  task automatic clear_model();
    q.delete();
    m_cnt  = '0;
    m_ovf  = 1'b0;
    m_drop = '0;
  endtask

  // Apply one cycle of inputs, advance the model across the edge, and
  // return 1 time unit after the edge so outputs can be sampled.
  task automatic drive(input logic r, input logic s, input logic [NR-1:0] rs,
                       input logic rdy);
    logic [OW-1:0] tag;
    bit            was_full;
    bit            pop;
    run           = r;
    start_of_data = s;
    report_states = rs;
    out_ready     = rdy;
    @(posedge clk);
    tag      = s ? '0 : m_cnt;
    was_full = (q.size() == DEPTH);
    pop      = rdy && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (r && (rs != '0)) begin
      if (!was_full || pop) q.push_back({tag, rs});
      else begin
        m_ovf = 1'b1;
        if (m_drop != '1) m_drop = m_drop + 1'b1;
      end
    end
    if (r) m_cnt = tag + 1'b1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    clear_model();
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; start_of_data = 1'b0;
    report_states = '0; out_ready = 1'b0;
    clear_model();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_offset !== '0) begin errors++; $display("FAIL reset_offset: got %h expected 0", out_offset); end
    checks++; if (out_vector !== '0) begin errors++; $display("FAIL reset_vector: got %h expected 0", out_vector); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (dropped_count !== '0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", dropped_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_first_report();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 0), (i == 3) ? 8'h04 : 8'h00, 1'b0);
      checks++;
      if (out_valid !== (i >= 3)) begin
        errors++; $display("FAIL first_valid[%0d]: got %b expected %b", i, out_valid, (i >= 3));
      end
    end
    checks++; if (out_offset !== 32'd3) begin errors++; $display("FAIL first_offset: got %0d expected 3", out_offset); end
    checks++; if (out_vector !== 8'h04) begin errors++; $display("FAIL first_vector: got %h expected 04", out_vector); end
    drive(1'b0, 1'b0, '0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_pop_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_sod_restart();
    do_reset();
    drive(1'b1, 1'b1, '0, 1'b0);
    for (int i = 0; i < 99; i++) drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h01, 1'b0);
    checks++; if (out_offset !== 32'd0 || out_vector !== 8'h01 || out_valid !== 1'b1) begin
      errors++; $display("FAIL sod_restart: got v=%b off=%0d vec=%h expected v=1 off=0 vec=01", out_valid, out_offset, out_vector);
    end
    drive(1'b1, 1'b0, 8'h02, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    checks++; if (out_offset !== 32'd1 || out_vector !== 8'h02) begin
      errors++; $display("FAIL sod_next: got off=%0d vec=%h expected off=1 vec=02", out_offset, out_vector);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sod_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [NR-1:0] vec [21];
    logic [OW-1:0] eo;
    logic [NR-1:0] ev;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      vec[i] = NR'($urandom_range(1, 255));
      drive(1'b1, (i == 0), vec[i], 1'b0);
    end
    checks++; if (dropped_count !== 16'd4) begin errors++; $display("FAIL ovf_dropped: got %0d expected 4", dropped_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (out_offset !== 32'd0 || out_vector !== vec[0]) begin
      errors++; $display("FAIL ovf_head: got off=%0d vec=%h expected off=0 vec=%h", out_offset, out_vector, vec[0]);
    end
    // Full, popping and pushing in the same cycle: nothing is lost.
    vec[20] = 8'hA5;
    drive(1'b1, 1'b0, vec[20], 1'b1);
    checks++; if (dropped_count !== 16'd4) begin errors++; $display("FAIL full_pop_push_dropped: got %0d expected 4", dropped_count); end
    for (int k = 0; k < 16; k++) begin
      eo = (k < 15) ? OW'(k + 1) : 32'd20;
      ev = (k < 15) ? vec[k+1] : vec[20];
      checks++;
      if (out_valid !== 1'b1 || out_offset !== eo || out_vector !== ev) begin
        errors++; $display("FAIL drain[%0d]: got v=%b off=%0d vec=%h expected v=1 off=%0d vec=%h", k, out_valid, out_offset, out_vector, eo, ev);
      end
      drive(1'b0, 1'b0, '0, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid: got %b expected 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_run_low();
    do_reset();
    drive(1'b1, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i == 1), 8'hFF, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL run_low_push[%0d]: got %b expected 0", i, out_valid); end
    end
    drive(1'b1, 1'b0, 8'h10, 1'b0);
    checks++; if (out_offset !== 32'd2 || out_vector !== 8'h10) begin
      errors++; $display("FAIL run_low_cnt: got off=%0d vec=%h expected off=2 vec=10", out_offset, out_vector);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, (i == 0), 8'h80, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, '0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_offset !== 32'd11 || overflow !== 1'b1) begin
      errors++; $display("FAIL pre_reset_state: got v=%b off=%0d ovf=%b expected v=1 off=11 ovf=1", out_valid, out_offset, overflow);
    end
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", out_valid); end
    checks++; if (out_offset !== '0 || out_vector !== '0) begin
      errors++; $display("FAIL async_data: got off=%0d vec=%h expected 0 0", out_offset, out_vector);
    end
    checks++; if (overflow !== 1'b0 || dropped_count !== '0) begin
      errors++; $display("FAIL async_counters: got ovf=%b drop=%0d expected 0 0", overflow, dropped_count);
    end
    @(posedge clk); #1;
    clear_model();
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'h08, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_offset !== 32'd0 || out_vector !== 8'h08) begin
      errors++; $display("FAIL post_reset_tag: got v=%b off=%0d vec=%h expected v=1 off=0 vec=08", out_valid, out_offset, out_vector);
    end
  endtask

  task automatic test_random();
    logic          r;
    logic          s;
    logic [NR-1:0] rs;
    logic          rdy;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 3) != 0);
      s   = ($urandom_range(0, 31) == 0);
      rs  = ($urandom_range(0, 2) == 0) ? '0 : NR'($urandom);
      rdy = ((i / 64) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      drive(r, s, rs, rdy);
      checks++;
      if (out_valid !== exp_valid() || out_offset !== exp_off() || out_vector !== exp_vec()) begin
        errors++;
        $display("FAIL rand_head[%0d]: got v=%b off=%0d vec=%h expected v=%b off=%0d vec=%h",
                 i, out_valid, out_offset, out_vector, exp_valid(), exp_off(), exp_vec());
      end
      checks++;
      if (overflow !== m_ovf || dropped_count !== m_drop) begin
        errors++;
        $display("FAIL rand_drop[%0d]: got ovf=%b drop=%0d expected ovf=%b drop=%0d",
                 i, overflow, dropped_count, m_ovf, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_report();
    test_sod_restart();
    test_overflow();
    test_run_low();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
